// File: rtl/ps2_mouse_rx_pkg.sv
// rtl/ps2_mouse_rx_pkg.sv - shared types, status bit indices and clamp helper for the PS/2 mouse receiver
package ps2_mouse_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } byte_state_e;

    localparam int LEFT   = 0;
    localparam int RIGHT  = 1;
    localparam int MIDDLE = 2;
    localparam int SYNC   = 3;
    localparam int XSIGN  = 4;
    localparam int YSIGN  = 5;
    localparam int XOVF   = 6;
    localparam int YOVF   = 7;

    localparam int DEF_X_RES = 800;
    localparam int DEF_Y_RES = 600;

    // Saturate a signed candidate coordinate into 0..lim-1.
    function automatic logic [11:0] clamp_pos(input logic signed [13:0] v, input int lim);
        int vi;
        vi = int'(v);
        if (vi < 0) begin
            vi = 0;
        end else if (vi > lim - 1) begin
            vi = lim - 1;
        end
        return 12'(vi);
    endfunction

endpackage

// File: rtl/ps2_mouse_rx_if.sv
// rtl/ps2_mouse_rx_if.sv - mouse position/button bus; PS2_MOUSE_EXTRA_BUTTONS_EN adds right/middle buttons
interface ps2_mouse_rx_if;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic        mouse_left;
    logic        packet_valid;
`ifdef PS2_MOUSE_EXTRA_BUTTONS_EN
    logic        mouse_right;
    logic        mouse_middle;

    modport master (output mouse_xpos, output mouse_ypos, output mouse_left,
                    output packet_valid, output mouse_right, output mouse_middle);
    modport slave  (input mouse_xpos, input mouse_ypos, input mouse_left,
                    input packet_valid, input mouse_right, input mouse_middle);
`else
    modport master (output mouse_xpos, output mouse_ypos, output mouse_left,
                    output packet_valid);
    modport slave  (input mouse_xpos, input mouse_ypos, input mouse_left,
                    input packet_valid);
`endif
endinterface

// File: rtl/ps2_rx_byte.sv
// rtl/ps2_rx_byte.sv - PS/2 line synchroniser, clock glitch filter, byte framing FSM and frame timeout
module ps2_rx_byte
    import ps2_mouse_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 40000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       byte_error_o
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic          clk_s;
    logic          data_s;
    logic [FW-1:0] filt_cnt_q;
    logic          filt_q;
    logic          fall;

    byte_state_e   state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [TW-1:0] tmo_q;
    logic [7:0]    byte_q;
    logic          byte_valid_q;
    logic          byte_error_q;

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    // Two-flop synchronisers for both asynchronous PS/2 lines, idling high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
        end
    end

    // Falling edge is the cycle the filter commits a high-to-low change.
    always_comb begin
        fall = filt_q && !clk_s && (filt_cnt_q == FW'(FILTER_LEN - 1));
    end

    // Filtered clock flips only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
        end else if (clk_s == filt_q) begin
            filt_cnt_q <= '0;
        end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
            filt_q     <= clk_s;
            filt_cnt_q <= '0;
        end else begin
            filt_cnt_q <= filt_cnt_q + 1'b1;
        end
    end

    // Frame FSM: start, 8 data LSB first, odd parity, stop; abandons stalled frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            tmo_q        <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            byte_error_q <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            byte_error_q <= 1'b0;
            if (fall) begin
                tmo_q <= '0;
            end else if (state_q != IDLE) begin
                tmo_q <= tmo_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (fall && !data_s) begin
                        state_q   <= DATA;
                        bit_cnt_q <= '0;
                    end
                end
                DATA: begin
                    if (fall) begin
                        shift_q   <= {data_s, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (fall) begin
                        parity_q <= data_s;
                        state_q  <= STOP;
                    end
                end
                STOP: begin
                    if (fall) begin
                        state_q <= IDLE;
                        if (data_s && (^{shift_q, parity_q})) begin
                            byte_q       <= shift_q;
                            byte_valid_q <= 1'b1;
                        end else begin
                            byte_error_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
            if ((state_q != IDLE) && !fall && (tmo_q == TW'(TIMEOUT_CYCLES - 1))) begin
                state_q      <= IDLE;
                tmo_q        <= '0;
                byte_error_q <= 1'b1;
            end
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = byte_valid_q;
    assign byte_error_o = byte_error_q;

endmodule

// File: rtl/ps2_mouse_rx.sv
// rtl/ps2_mouse_rx.sv - 3-byte PS/2 mouse packet assembly and clamped absolute cursor; PS2_MOUSE_EXTRA_BUTTONS_EN adds right/middle
module ps2_mouse_rx
    import ps2_mouse_pkg::*;
#(
    parameter int X_RES          = DEF_X_RES,
    parameter int Y_RES          = DEF_Y_RES,
    parameter int INIT_X         = 400,
    parameter int INIT_Y         = 300,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 40000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ps2_clk,
    input  logic            ps2_data,
    ps2_mouse_rx_if.master  mouse
);

    logic [7:0]         byte_w;
    logic               byte_valid_w;
    logic               byte_error_w;

    logic [1:0]         idx_q;
    logic [7:0]         status_q;
    logic [7:0]         dx_q;
    logic [11:0]        xpos_q;
    logic [11:0]        ypos_q;
    logic               left_q;
    logic               valid_q;
    logic signed [13:0] dx14;
    logic signed [13:0] dy14;
    logic signed [13:0] new_x;
    logic signed [13:0] new_y;

    ps2_rx_byte #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx_byte (
        .clk          (clk),
        .rst_n        (rst),
        .ps2_clk_i    (ps2_clk),
        .ps2_data_i   (ps2_data),
        .byte_o       (byte_w),
        .byte_valid_o (byte_valid_w),
        .byte_error_o (byte_error_w)
    );

    // Candidate position from the stored status/dx and the arriving dy byte.
    always_comb begin
        dx14  = status_q[XOVF] ? 14'sd0
              : $signed({{5{status_q[XSIGN]}}, status_q[XSIGN], dx_q});
        dy14  = status_q[YOVF] ? 14'sd0
              : $signed({{5{status_q[YSIGN]}}, status_q[YSIGN], byte_w});
        new_x = $signed({2'b00, xpos_q}) + dx14;
        new_y = $signed({2'b00, ypos_q}) - dy14;
    end

    // Packet index tracking and output update on the third good byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q    <= 2'd0;
            status_q <= '0;
            dx_q     <= '0;
            xpos_q   <= 12'(INIT_X);
            ypos_q   <= 12'(INIT_Y);
            left_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (byte_error_w) begin
                idx_q <= 2'd0;
            end else if (byte_valid_w) begin
                case (idx_q)
                    2'd0: begin
                        if (byte_w[SYNC]) begin
                            status_q <= byte_w;
                            idx_q    <= 2'd1;
                        end
                    end
                    2'd1: begin
                        dx_q  <= byte_w;
                        idx_q <= 2'd2;
                    end
                    2'd2: begin
                        idx_q   <= 2'd0;
                        xpos_q  <= clamp_pos(new_x, X_RES);
                        ypos_q  <= clamp_pos(new_y, Y_RES);
                        left_q  <= status_q[LEFT];
                        valid_q <= 1'b1;
                    end
                    default: idx_q <= 2'd0;
                endcase
            end
        end
    end

`ifdef PS2_MOUSE_EXTRA_BUTTONS_EN
    logic right_q;
    logic middle_q;

    // Right/middle buttons latch alongside the left button at packet completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            right_q  <= 1'b0;
            middle_q <= 1'b0;
        end else if (byte_valid_w && !byte_error_w && (idx_q == 2'd2)) begin
            right_q  <= status_q[RIGHT];
            middle_q <= status_q[MIDDLE];
        end
    end

    assign mouse.mouse_right  = right_q;
    assign mouse.mouse_middle = middle_q;
`else
    logic unused_buttons;
    assign unused_buttons = ^status_q[MIDDLE:RIGHT];
`endif

    assign mouse.mouse_xpos   = xpos_q;
    assign mouse.mouse_ypos   = ypos_q;
    assign mouse.mouse_left   = left_q;
    assign mouse.packet_valid = valid_q;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// tb/tb_ps2_mouse_rx.sv - directed PS/2 packet stimulus with a position model and per-cycle output comparison
module tb_ps2_mouse_rx;

    localparam int HP      = 10;
    localparam int FLEN    = 4;
    localparam int TMO     = 300;
    localparam int XR      = 800;
    localparam int YR      = 600;

    typedef struct {
        int x;
        int y;
        int l;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    int n_pass = 0;
    int n_total = 0;

    exp_t exp_q[$];
    int mx = 400;
    int my = 300;
    int ml = 0;
    int cur_x = 400;
    int cur_y = 300;
    int cur_l = 0;

    ps2_mouse_rx_if mif ();

    ps2_mouse_rx #(
        .X_RES          (XR),
        .Y_RES          (YR),
        .INIT_X         (400),
        .INIT_Y         (300),
        .FILTER_LEN     (FLEN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .mouse    (mif)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cyc(HP);
        ps2_clk = 1'b0;
        wait_cyc(HP);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_parity);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_parity);
        send_bit(1'b1);
        ps2_data = 1'b1;
        wait_cyc(2 * HP);
    endtask

    task automatic model_packet(input logic [7:0] s, input logic [7:0] dx, input logic [7:0] dy);
        int ddx;
        int ddy;
        exp_t e;
        ddx = s[6] ? 0 : (s[4] ? int'(dx) - 256 : int'(dx));
        ddy = s[7] ? 0 : (s[5] ? int'(dy) - 256 : int'(dy));
        mx = clampi(mx + ddx, XR - 1);
        my = clampi(my - ddy, YR - 1);
        ml = int'(s[0]);
        e.x = mx;
        e.y = my;
        e.l = ml;
        exp_q.push_back(e);
    endtask

    task automatic wait_drained(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk(name, exp_q.size(), 0);
    endtask

    task automatic good_packet(input logic [7:0] s, input logic [7:0] dx, input logic [7:0] dy);
        model_packet(s, dx, dy);
        send_byte(s, 1'b0);
        send_byte(dx, 1'b0);
        send_byte(dy, 1'b0);
        wait_drained("packet_strobe");
    endtask

    task automatic do_reset();
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rst = 1'b0;
        exp_q.delete();
        mx = 400;
        my = 300;
        ml = 0;
        wait_cyc(5);
        rst = 1'b1;
        wait_cyc(5);
    endtask

    task automatic chk_pos(input string name, input int x, input int y, input int l);
        chk({name, "_x"}, int'(mif.mouse_xpos), x);
        chk({name, "_y"}, int'(mif.mouse_ypos), y);
        chk({name, "_left"}, int'(mif.mouse_left), l);
    endtask

    // Per-cycle comparison against the model's most recently retired packet.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                cur_x = 400;
                cur_y = 300;
                cur_l = 0;
                chk("rst_valid", int'(mif.packet_valid), 0);
            end else if (mif.packet_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    cur_x = e.x;
                    cur_y = e.y;
                    cur_l = e.l;
                end
            end
            chk("cyc_x", int'(mif.mouse_xpos), cur_x);
            chk("cyc_y", int'(mif.mouse_ypos), cur_y);
            chk("cyc_left", int'(mif.mouse_left), cur_l);
        end
    end

    initial begin
        // Reset and idle lines.
        wait_cyc(3);
        chk_pos("in_reset", 400, 300, 0);
        do_reset();
        wait_cyc(200);
        chk_pos("idle", 400, 300, 0);

        // Basic packet with left button.
        good_packet(8'h09, 8'h0A, 8'h05);
        chk_pos("pkt_09", 410, 295, 1);

        // Negative dx, then both axes at -128.
        do_reset();
        good_packet(8'h18, 8'hF6, 8'h00);
        chk_pos("pkt_18", 390, 300, 0);
        good_packet(8'h38, 8'h80, 8'h80);
        chk_pos("pkt_38", 262, 428, 0);

        // Saturate right edge.
        do_reset();
        for (int i = 0; i < 47; i++) good_packet(8'h08, 8'h7F, 8'h00);
        chk_pos("clamp_x", 799, 300, 0);

        // Saturate top edge.
        for (int i = 0; i < 3; i++) good_packet(8'h08, 8'h00, 8'h7F);
        chk_pos("clamp_y", 799, 0, 0);

        // Parity error on dx byte; trailing byte lacks sync bit and is dropped too.
        do_reset();
        send_byte(8'h08, 1'b0);
        send_byte(8'h10, 1'b1);
        send_byte(8'h05, 1'b0);
        wait_cyc(50);
        chk_pos("parity_drop", 400, 300, 0);
        good_packet(8'h08, 8'h05, 8'h02);
        chk_pos("after_parity", 405, 298, 0);

        // Stall mid-frame after a good status byte; timeout must clear the packet index.
        send_byte(8'h08, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        wait_cyc(2 * TMO + 100);
        chk_pos("stall_hold", 405, 298, 0);
        good_packet(8'h09, 8'h01, 8'h01);
        chk_pos("after_stall", 406, 297, 1);

        // Reset after the first byte of a packet.
        send_byte(8'h08, 1'b0);
        do_reset();
        chk_pos("mid_reset", 400, 300, 0);
        good_packet(8'h08, 8'h02, 8'h03);
        chk_pos("after_reset", 402, 297, 0);

        wait_cyc(20);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_rx.md
Name: ps2_mouse_rx

Overview:
- Mouse-side producer of the `mouse_left`, `mouse_xpos` and `mouse_ypos` signals consumed by the rectangle/ball control logic.
- Receives raw PS/2 mouse frames, assembles standard 3-byte movement packets, and keeps an absolute, screen-clamped cursor position.
- Sits between the board PS/2 pins and draw/control blocks in the 40 MHz domain.

Parameters:
- X_RES, 800, horizontal screen size in pixels; xpos clamped to 0..X_RES-1.
- Y_RES, 600, vertical screen size in pixels; ypos clamped to 0..Y_RES-1.
- INIT_X, 400, xpos after reset.
- INIT_Y, 300, ypos after reset.
- FILTER_LEN, 8, consecutive equal samples required to accept a ps2_clk level change.
- TIMEOUT_CYCLES, 40000, idle clk cycles mid-frame before the frame is abandoned (1 ms at 40 MHz).

Ports:
- clk  in  1  system clock, 40 MHz.
- rst  in  1  asynchronous active-low reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- mouse_xpos  out  12  absolute x position.
- mouse_ypos  out  12  absolute y position, screen convention (down = +).
- mouse_left  out  1  left button state from last valid packet.
- packet_valid  out  1  one-cycle strobe when a packet updates the outputs.

Behaviour:
- Reset (async, rst=0): mouse_xpos=INIT_X, mouse_ypos=INIT_Y, mouse_left=0, packet_valid=0; byte FSM to IDLE; packet index to 0; filter and synchronisers to 1.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - ps2_clk is then glitch-filtered: the filtered level changes only after FILTER_LEN equal samples.
  - Data is sampled on each filtered falling edge.
- Byte FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: a falling edge with data=0 is the start bit -> DATA. A falling edge with data=1 is ignored.
  - DATA: 8 bits, LSB first -> PARITY.
  - PARITY: sample the parity bit -> STOP.
  - STOP: sample the stop bit -> IDLE. The byte is accepted only if the 9 bits (data + parity) have odd parity and stop=1.
- Bad byte: a parity or stop error discards the byte and resets the packet index to 0.
- Timeout: outside IDLE, a timeout counter restarts on every falling edge. At TIMEOUT_CYCLES it forces IDLE and packet index 0, with no output change.
- Packet assembly:
  - Index 0: accept only if byte bit3=1, otherwise drop and stay at index 0. Store the status byte.
  - Index 1: dx. Index 2: dy.
- Packet completion, on the clk after the third stop bit is accepted:
  - dx9 = {status[4], dx}, dy9 = {status[5], dy}, both signed 9-bit.
  - If status[6] (x overflow) is set, dx is treated as 0. If status[7] (y overflow) is set, dy is treated as 0.
  - new_x = xpos + dx9; new_y = ypos − dy9. Compute in signed 14-bit, then saturate to [0, X_RES-1] and [0, Y_RES-1].
  - mouse_left = status[0].
  - packet_valid is high for exactly that one cycle.
- Latency: outputs are valid 1 clk after the filtered falling edge that samples the third stop bit.
- Reset mid-packet: all partial state is lost; the next start bit begins a new packet at index 0.
- Outputs hold their values between packets.

Optional Feature:
- Macro: PS2_MOUSE_EXTRA_BUTTONS_EN.
- When defined:
  - Adds output ports mouse_right (status[1]) and mouse_middle (status[2]).
  - Both are registered on packet completion and reset to 0.
- When undefined:
  - These ports do not exist; status bits 1 and 2 are ignored.

Decomposition:
- Package ps2_mouse_pkg holds:
  - the byte-FSM state enum;
  - status bit index constants: LEFT=0, RIGHT=1, MIDDLE=2, SYNC=3, XSIGN=4, YSIGN=5, XOVF=6, YOVF=7;
  - default X_RES/Y_RES.
- Sub-module ps2_rx_byte contains synchroniser, filter, byte FSM and timeout. Its outputs are byte[7:0], byte_valid and byte_error.
- The top level does packet assembly and position arithmetic.

Test Plan:
- Reset then idle lines -> xpos=400, ypos=300, left=0, packet_valid never asserts.
- Packet 0x09, 0x0A, 0x05 -> one packet_valid pulse; xpos=410, ypos=295, left=1.
- From reset, packet 0x18, 0xF6, 0x00 -> xpos=390, left=0. Then 0x38, 0x80, 0x80 (dx=−128, dy=−128) -> xpos=262, ypos=428.
- Clamp cases:
  - Forty-seven packets of 0x08, 0x7F, 0x00 (+127 each) from xpos=400 -> saturates at xpos=799, never wraps.
  - Packet 0x08, 0x00, 0x7F from ypos=300, repeated 3x -> ypos=0.
- Parity error on byte 1 -> packet dropped, no strobe, outputs unchanged. The next good packet is applied normally.
- Mid-frame stall and reset:
  - Send start + 4 data bits, then stall 2 ms -> frame abandoned. The next full packet is decoded correctly.
  - Assert rst after byte 1 -> outputs return to 400/300/0.
